// File: rtl/axi_wr_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the line-buffer write master
// and the memory-side slave. Only the channel subset this master uses.
interface axi_wr_master_if #(
   parameter int AXI_ADDR_WIDTH = 29,
   parameter int DQ_WIDTH       = 32
);

   logic [AXI_ADDR_WIDTH-1:0] axi_awaddr;
   logic [7:0]                axi_awlen;
   logic                      axi_awvalid;
   logic                      axi_awready;

   logic [8*DQ_WIDTH-1:0]     axi_wdata;
   logic [DQ_WIDTH-1:0]       axi_wstrb;
   logic                      axi_wlast;
   logic                      axi_wvalid;
   logic                      axi_wready;

   logic                      axi_bvalid;
   logic [1:0]                axi_bresp;
   logic                      axi_bready;

   modport master (
      output axi_awaddr,
      output axi_awlen,
      output axi_awvalid,
      input  axi_awready,
      output axi_wdata,
      output axi_wstrb,
      output axi_wlast,
      output axi_wvalid,
      input  axi_wready,
      input  axi_bvalid,
      input  axi_bresp,
      output axi_bready
   );

   modport slave (
      input  axi_awaddr,
      input  axi_awlen,
      input  axi_awvalid,
      output axi_awready,
      input  axi_wdata,
      input  axi_wstrb,
      input  axi_wlast,
      input  axi_wvalid,
      output axi_wready,
      output axi_bvalid,
      output axi_bresp,
      input  axi_bready
   );

endinterface

// File: rtl/axi_wr_master.sv
// Line-buffer to AXI4 write master. A line (start word address + length in
// beats) is split into bursts of at most MAX_BURST beats. Each burst runs
// AW handshake, then all W beats streamed straight from the upstream buffer,
// then the B response, before the next burst is issued.
module axi_wr_master #(
   parameter int ADDR_WIDTH = 27,
   parameter int DQ_WIDTH   = 32,
   parameter int LEN_WIDTH  = 32,
   parameter int MAX_BURST  = 16,
   parameter int ADDR_SHIFT = 2
) (
   input  logic                    ddr_clk,
   input  logic                    ddr_rstn,
   input  logic                    ddr_wreq,
   input  logic [ADDR_WIDTH-1:0]   ddr_waddr,
   input  logic [LEN_WIDTH-1:0]    ddr_wr_len,
   output logic                    ddr_wrdy,
   output logic                    ddr_wdone,
   input  logic [8*DQ_WIDTH-1:0]   ddr_wdata,
   output logic                    ddr_wdata_req,
   output logic                    wr_err,
   axi_wr_master_if.master         axi
);

   localparam int AXI_AW = ADDR_WIDTH + ADDR_SHIFT;

   typedef enum logic [2:0] {
      IDLE,
      AW,
      W,
      B,
      DONE
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [AXI_AW-1:0]     addr_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic [8:0]            beats_q;
   logic [8:0]            beat_cnt_q;

   logic [AXI_AW-1:0]     awaddr_q;
   logic [7:0]            awlen_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  wlast_q;
   logic                  bready_q;
   logic                  wr_err_q;

   logic                  w_fire;
   logic                  aw_fire;
   logic                  b_fire;
   logic [AXI_AW-1:0]     start_byte;
   logic [AXI_AW-1:0]     burst_bytes;
   logic [AXI_AW-1:0]     next_addr;
   logic [LEN_WIDTH-1:0]  next_remaining;
   logic [LEN_WIDTH-1:0]  plan_len;
   logic [AXI_AW-1:0]     plan_addr;
   logic [8:0]            plan_beats;

   assign aw_fire = awvalid_q & axi.axi_awready;
   assign w_fire  = wvalid_q & axi.axi_wready;
   assign b_fire  = bready_q & axi.axi_bvalid;

   // Burst planning: where the next burst starts and how many beats it
   // carries, taken from the request in IDLE or from the post-response
   // remainder in B, so the AW registers load in the same edge as the move.
   always_comb begin
      start_byte     = AXI_AW'(ddr_waddr) << ADDR_SHIFT;
      burst_bytes    = AXI_AW'(beats_q) * AXI_AW'(DQ_WIDTH);
      next_addr      = addr_q + burst_bytes;
      next_remaining = remaining_q - LEN_WIDTH'(beats_q);
      plan_len       = next_remaining;
      plan_addr      = next_addr;
      if (state_q == IDLE) begin
         plan_len  = ddr_wr_len;
         plan_addr = start_byte;
      end
      plan_beats = 9'(plan_len);
      if (plan_len >= LEN_WIDTH'(MAX_BURST)) begin
         plan_beats = 9'(MAX_BURST);
      end
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode plus the upstream-facing status outputs.
   always_comb begin
      state_d   = state_q;
      ddr_wrdy  = 1'b0;
      ddr_wdone = 1'b0;
      case (state_q)
         IDLE: begin
            ddr_wrdy = 1'b1;
            if (ddr_wreq) begin
               if (ddr_wr_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = AW;
               end
            end
         end
         AW: begin
            if (aw_fire) begin
               state_d = W;
            end
         end
         W: begin
            if (w_fire && wlast_q) begin
               state_d = B;
            end
         end
         B: begin
            if (b_fire) begin
               if (next_remaining != '0) begin
                  state_d = AW;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            ddr_wdone = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line bookkeeping and registered AXI channel controls. Valid/last/ready
   // are loaded on the transition into the state that owns them so every
   // AXI control output is a plain flop.
   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         addr_q      <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         beat_cnt_q  <= '0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
         bready_q    <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ddr_wreq) begin
                  addr_q      <= start_byte;
                  remaining_q <= ddr_wr_len;
                  if (ddr_wr_len != '0) begin
                     beats_q   <= plan_beats;
                     awaddr_q  <= plan_addr;
                     awlen_q   <= 8'(plan_beats - 9'd1);
                     awvalid_q <= 1'b1;
                  end
               end
            end
            AW: begin
               if (aw_fire) begin
                  awvalid_q  <= 1'b0;
                  wvalid_q   <= 1'b1;
                  wlast_q    <= (beats_q == 9'd1);
                  beat_cnt_q <= '0;
               end
            end
            W: begin
               if (w_fire) begin
                  if (wlast_q) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     bready_q <= 1'b1;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 9'd1;
                     wlast_q    <= (beat_cnt_q + 9'd2 == beats_q);
                  end
               end
            end
            B: begin
               if (b_fire) begin
                  bready_q    <= 1'b0;
                  remaining_q <= next_remaining;
                  addr_q      <= next_addr;
                  if (axi.axi_bresp != 2'b00) begin
                     wr_err_q <= 1'b1;
                  end
                  if (next_remaining != '0) begin
                     beats_q   <= plan_beats;
                     awaddr_q  <= plan_addr;
                     awlen_q   <= 8'(plan_beats - 9'd1);
                     awvalid_q <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign axi.axi_awaddr  = awaddr_q;
   assign axi.axi_awlen   = awlen_q;
   assign axi.axi_awvalid = awvalid_q;
   assign axi.axi_wvalid  = wvalid_q;
   assign axi.axi_wlast   = wlast_q;
   assign axi.axi_bready  = bready_q;
   assign axi.axi_wdata   = ddr_wdata;
   assign axi.axi_wstrb   = '1;
   assign ddr_wdata_req   = w_fire;
   assign wr_err          = wr_err_q;

endmodule
